// File: rtl/stage3.sv
// Execute stage of the 5-stage MIPS pipeline.
// Single-cycle integer ALU, an iterative shift-add multiplier and a start/done
// handshake to the external FP unit, all feeding the EX/MEM pipeline register.
// Stall_out is combinational and tells stages 1-2 to hold while a multi-cycle
// operation is in flight.

module stage3 #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En_Pipeline,

    // Decoded control bundle from stage2
    input  logic [5:0]        ALU_Op_Code_in,
    input  logic              ALU_src_in,
    input  logic              En_Integer_in,
    input  logic              En_Float_in,
    input  logic              Memory_Read_in,
    input  logic              Memory_Write_in,
    input  logic              Reg_Write_En_in,
    input  logic              WB_Mux_sel_in,
    input  logic              BR_flag_in,
    input  logic [4:0]        Addr_Write_Reg_in,

    // Operands (already forwarded)
    input  logic [DATA_W-1:0] data1_in,
    input  logic [DATA_W-1:0] data2_in,
    input  logic [15:0]       imm_in,

    // FP unit handshake
    input  logic [DATA_W-1:0] Float_Result_in,
    input  logic              Float_Done_in,
    output logic              Float_Start_out,
    output logic [DATA_W-1:0] Float_A_out,
    output logic [DATA_W-1:0] Float_B_out,

    // EX/MEM pipeline register
    output logic [DATA_W-1:0] ALU_Result_out,
    output logic [DATA_W-1:0] Store_Data_out,
    output logic [4:0]        Addr_Write_Reg_out,
    output logic              Memory_Read_out,
    output logic              Memory_Write_out,
    output logic              Reg_Write_En_out,
    output logic              WB_Mux_sel_out,
    output logic              Branch_Taken_out,

    output logic              Stall_out
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_XOR   = 6'd4;
    localparam logic [5:0] OP_SLL   = 6'd5;
    localparam logic [5:0] OP_SRL   = 6'd6;
    localparam logic [5:0] OP_SLT   = 6'd7;
    localparam logic [5:0] OP_MUL   = 6'd8;
    localparam logic [5:0] OP_PASSB = 6'd9;

    typedef enum logic [1:0] {
        StIdle,
        StMulBusy,
        StFltWait
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   mul_cnt_q;
    logic [DATA_W-1:0]  mul_acc_q;
    logic [DATA_W-1:0]  mul_a_q;
    logic [DATA_W-1:0]  mul_b_q;

    logic [DATA_W-1:0]  operand_b;
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  mul_acc_d;
    logic [DATA_W-1:0]  ex_result;
    logic               mul_entry;
    logic               flt_entry;
    logic               mul_last;
    logic               load_valid;
    logic               slt_flag;
    logic [SH_W-1:0]    shamt;

    // Operand B select: sign-extended immediate or second register operand
    always_comb begin
        operand_b = ALU_src_in ? {{(DATA_W-16){imm_in[15]}}, imm_in} : data2_in;
        shamt     = operand_b[SH_W-1:0];
        slt_flag  = $signed(data1_in) < $signed(operand_b);
    end

    // Single-cycle integer ALU; MUL is handled by the iterative multiplier
    always_comb begin
        alu_result = '0;
        case (ALU_Op_Code_in)
            OP_ADD:   alu_result = data1_in + operand_b;
            OP_SUB:   alu_result = data1_in - operand_b;
            OP_AND:   alu_result = data1_in & operand_b;
            OP_OR:    alu_result = data1_in | operand_b;
            OP_XOR:   alu_result = data1_in ^ operand_b;
            OP_SLL:   alu_result = data1_in << shamt;
            OP_SRL:   alu_result = data1_in >> shamt;
            OP_SLT:   alu_result = {{(DATA_W-1){1'b0}}, slt_flag};
            OP_PASSB: alu_result = operand_b;
            default:  alu_result = '0;
        endcase
    end

    // Multiplier step: add A<<k when bit k of B is set
    always_comb begin
        mul_acc_d = mul_acc_q;
        if (mul_b_q[mul_cnt_q]) begin
            mul_acc_d = mul_acc_q + (mul_a_q << mul_cnt_q);
        end
    end

    // Entry / completion decode and the upstream stall
    always_comb begin
        flt_entry = (state_q == StIdle) && En_Float_in;
        mul_entry = (state_q == StIdle) && !En_Float_in && En_Integer_in
                    && (ALU_Op_Code_in == OP_MUL);
        mul_last  = (state_q == StMulBusy) && (mul_cnt_q == CNT_LAST);

        Stall_out = 1'b0;
        unique case (state_q)
            StIdle:    Stall_out = flt_entry || mul_entry;
            StMulBusy: Stall_out = !mul_last;
            StFltWait: Stall_out = !Float_Done_in;
            default:   Stall_out = 1'b0;
        endcase

        // A frozen pipeline must not re-issue the FP start
        Float_Start_out = flt_entry && En_Pipeline;
    end

    // What the EX/MEM register loads this cycle: a real result or a bubble
    always_comb begin
        load_valid = 1'b0;
        ex_result  = '0;
        unique case (state_q)
            StIdle: begin
                load_valid = !(flt_entry || mul_entry);
                ex_result  = En_Integer_in ? alu_result : operand_b;
            end
            StMulBusy: begin
                load_valid = mul_last;
                ex_result  = mul_acc_d;
            end
            StFltWait: begin
                load_valid = Float_Done_in;
                ex_result  = Float_Result_in;
            end
            default: begin
                load_valid = 1'b0;
                ex_result  = '0;
            end
        endcase
    end

    // FSM, multiplier state and FP operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mul_cnt_q   <= '0;
            mul_acc_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            Float_A_out <= '0;
            Float_B_out <= '0;
        end else if (En_Pipeline) begin
            unique case (state_q)
                StIdle: begin
                    if (flt_entry) begin
                        Float_A_out <= data1_in;
                        Float_B_out <= operand_b;
                        state_q     <= StFltWait;
                    end else if (mul_entry) begin
                        mul_a_q   <= data1_in;
                        mul_b_q   <= operand_b;
                        mul_cnt_q <= '0;
                        mul_acc_q <= '0;
                        state_q   <= StMulBusy;
                    end
                end
                StMulBusy: begin
                    mul_acc_q <= mul_acc_d;
                    mul_cnt_q <= mul_cnt_q + 1'b1;
                    if (mul_last) begin
                        state_q <= StIdle;
                    end
                end
                StFltWait: begin
                    if (Float_Done_in) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // EX/MEM pipeline register: result plus control, or an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ALU_Result_out     <= '0;
            Store_Data_out     <= '0;
            Addr_Write_Reg_out <= '0;
            Memory_Read_out    <= 1'b0;
            Memory_Write_out   <= 1'b0;
            Reg_Write_En_out   <= 1'b0;
            WB_Mux_sel_out     <= 1'b0;
            Branch_Taken_out   <= 1'b0;
        end else if (En_Pipeline) begin
            if (load_valid) begin
                ALU_Result_out     <= ex_result;
                Store_Data_out     <= data2_in;
                Addr_Write_Reg_out <= Addr_Write_Reg_in;
                Memory_Read_out    <= Memory_Read_in;
                Memory_Write_out   <= Memory_Write_in;
                Reg_Write_En_out   <= Reg_Write_En_in;
                WB_Mux_sel_out     <= WB_Mux_sel_in;
                Branch_Taken_out   <= BR_flag_in && (data1_in == data2_in);
            end else begin
                ALU_Result_out     <= '0;
                Store_Data_out     <= '0;
                Addr_Write_Reg_out <= '0;
                Memory_Read_out    <= 1'b0;
                Memory_Write_out   <= 1'b0;
                Reg_Write_En_out   <= 1'b0;
                WB_Mux_sel_out     <= 1'b0;
                Branch_Taken_out   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/stage3.md
Name: stage3

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the decoded control bundle and operands produced by stage2 (decode/register-file/SP).
- Computes the integer ALU result, runs an iterative multi-cycle multiplier, and drives a start/done handshake to the external floating-point DSP unit.
- Registers everything into the EX/MEM pipeline register consumed by stage4 (memory), and raises Stall_out back to stages 1–2 while a multi-cycle operation is in flight.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_CYCLES, 32, iterations of the shift-add multiplier (one bit of B per cycle).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- En_Pipeline  in  1  global advance enable; 0 freezes the FSM and all registers.
- ALU_Op_Code_in  in  6  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT(signed), 8 MUL, 9 PASSB; others → result 0.
- ALU_src_in  in  1  1: operand B = sign-extended imm_in; 0: data2_in.
- En_Integer_in  in  1  integer op valid.
- En_Float_in  in  1  float op; result comes from the FP unit.
- Memory_Read_in, Memory_Write_in, Reg_Write_En_in, WB_Mux_sel_in  in  1 each  control pass-through.
- BR_flag_in  in  1  conditional branch (taken if data1_in == data2_in).
- Addr_Write_Reg_in  in  5  destination register.
- data1_in, data2_in  in  32  operands (already forwarded).
- imm_in  in  16  immediate.
- Float_Result_in  in  32  FP unit result.
- Float_Done_in  in  1  FP unit completion pulse.
- Float_Start_out  out  1  one-cycle FP start pulse.
- Float_A_out, Float_B_out  out  32  FP operands; held stable during the wait.
- ALU_Result_out  out  32  EX/MEM result (also the memory address).
- Store_Data_out  out  32  EX/MEM copy of data2_in.
- Addr_Write_Reg_out  out  5  EX/MEM destination register.
- Memory_Read_out, Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out  out  1 each  EX/MEM control.
- Branch_Taken_out  out  1  registered branch decision.
- Stall_out  out  1  combinational; upstream must hold its outputs while it is high.

Behaviour:
- Reset (synchronous, active-high, overrides En_Pipeline): all outputs 0, FSM → IDLE, multiplier counter and accumulator 0. Reset mid-MUL or mid-float wait aborts the operation; a Float_Done_in arriving later is ignored.
- FSM states: IDLE, MUL_BUSY, FLT_WAIT.
- Single-cycle ops (IDLE, En_Pipeline=1, not MUL, not float): EX/MEM loads the result at the next edge, giving one-cycle latency.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32 with no overflow flag.
  - SLL/SRL shift by B[4:0] and are logical.
  - SLT gives 1 if signed A < signed B, else 0.
- MUL entry (IDLE, En_Integer_in=1, op 8):
  - Stall_out=1 in the same cycle.
  - EX/MEM loads a bubble (all control outputs 0).
  - Operands latch and the FSM goes to MUL_BUSY.
- MUL_BUSY:
  - Each cycle adds A<<k to the accumulator if B[k]=1; the counter increments.
  - Stall_out=1 and a bubble loads each cycle, except in the final cycle (counter = MUL_CYCLES-1).
  - Final cycle: Stall_out=0; EX/MEM loads the low 32 bits of the product plus the control inputs (still held upstream); FSM → IDLE.
  - Result is valid on ALU_Result_out MUL_CYCLES+1 = 33 edges after entry.
- Float entry (IDLE, En_Float_in=1):
  - Float_Start_out=1 for exactly that cycle.
  - Float_A/B_out are registered from data1_in and operand B.
  - Stall_out=1 and a bubble loads; FSM → FLT_WAIT.
- FLT_WAIT:
  - Stall_out=1 and bubbles load until Float_Done_in=1.
  - In the Float_Done_in=1 cycle: Stall_out=0; EX/MEM loads Float_Result_in plus control; FSM → IDLE.
  - Float_Done_in while in IDLE is ignored.
- Priority and conflicts:
  - En_Float_in takes priority over En_Integer_in if both are set.
  - Neither set: EX/MEM still loads control, with ALU_Result_out = PASSB value.
- Branch: Branch_Taken_out is registered as (BR_flag_in & data1_in == data2_in) and is 0 on bubbles. Flushing is the fetch stage's responsibility.
- En_Pipeline=0:
  - All registers, the counter and the FSM hold.
  - Stall_out keeps its combinational value.
  - Float_Start_out is forced 0 and never repeats.

Test Plan:
- Reset, then ADD with data1=7, ALU_src=1, imm=16'd18 → ALU_Result_out=25 one edge later; Reg_Write_En_out follows the input.
- SUB 2−9 → 32'hFFFFFFF9; SLT(2,−1) → 0; SLL 1 by imm 31 → 32'h80000000; imm=16'hFFFF sign-extends to −1.
- MUL 9×7 → Stall_out high for 32 cycles, 32 bubbles at the outputs, then ALU_Result_out=63 after edge 33; upstream holds inputs throughout.
- Float op with Float_Done_in returned 5 cycles after start, Float_Result_in=32'h40490FDB → exactly one Float_Start_out pulse, stall released in the done cycle, result registered.
- BR_flag with data1=data2=2 → Branch_Taken_out=1; data2=3 → 0.
- Reset asserted at MUL iteration 10 → next edge all outputs 0, FSM IDLE, Stall_out=0; En_Pipeline=0 mid-MUL extends completion by exactly the frozen cycles.
